// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//
// Purpose:
//   Shared types and constants for the five-stage pipeline hazard logic.
//   Holds the forwarding-select encoding, the hazard FSM state type, the
//   default drain length, and a small helper that detects the load-use case.
//
// Contents:
//   fwd_sel_t             ALU operand source select (register file / W / M)
//   hz_state_t            hazard/debug FSM states
//   DRAIN_CYCLES_DEFAULT  cycles needed to empty D/E/M/W on a halt
//   REG_X0                architectural zero register index
//   is_load_use()         load in execute feeding a source in decode
// ---------------------------------------------------------------------------
package pipe_pkg;

  // The encodings are fixed because the datapath operand muxes decode
  // these exact bit patterns.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'b00,
    HZ_DRAIN  = 2'b01,
    HZ_HALTED = 2'b10,
    HZ_STEP   = 2'b11
  } hz_state_t;

  localparam int DRAIN_CYCLES_DEFAULT = 4;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A load in execute only hurts when its destination is a real register
  // that the decode-stage instruction reads; x0 writes are discarded.
  function automatic logic is_load_use(
    input logic       load_e,
    input logic [4:0] rd_e,
    input logic [4:0] rs1_d,
    input logic [4:0] rs2_d
  );
    return load_e && (rd_e != REG_X0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  endfunction

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
//
// Purpose:
//   Chooses the source of one ALU operand in execute. The youngest producer
//   (memory stage) wins over the older one (writeback stage), and x0 is
//   never forwarded because its architectural value is always zero.
//
// Ports:
//   rs_e         in   5  source register of the operand in execute
//   rd_m         in   5  memory-stage destination
//   reg_write_m  in   1  memory-stage write enable
//   rd_w         in   5  writeback-stage destination
//   reg_write_w  in   1  writeback-stage write enable
//   fwd_sel      out  2  operand source select (fwd_sel_t)
// ---------------------------------------------------------------------------
module forward_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output fwd_sel_t   fwd_sel
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m && (rd_m != REG_X0) && (rd_m == rs_e);
  assign hit_w = reg_write_w && (rd_w != REG_X0) && (rd_w == rs_e);

  // Priority select: the memory-stage result is newer than the writeback
  // result, so when both stages target the same register the M-stage value
  // is the one the instruction in execute must see.
  always_comb begin
    fwd_sel = FWD_RF;
    if (hit_m) begin
      fwd_sel = FWD_M;
    end else if (hit_w) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//
// Purpose:
//   Pipeline hazard unit with a debug halt/single-step sequencer.
//   - Operand forwarding for both ALU sources in execute.
//   - One-bubble load-use stall.
//   - Branch/jump flush of F/D and D/E, which beats the load-use stall.
//   - Halt sequencer: on a halt request the front end is frozen and bubbles
//     are injected for DRAIN_CYCLES cycles so D/E/M/W empty out, then the
//     core sits quiescent (halted = 1). A step pulse while halted lets one
//     instruction into decode and drains again.
//
// Parameters:
//   DRAIN_CYCLES  cycles needed to empty the D/E/M/W stages (>= 1)
//
// Ports:
//   clk                 in   1  clock
//   srst                in   1  synchronous active-high reset
//   rs1_d, rs2_d        in   5  sources of the instruction in decode
//   rs1_e, rs2_e, rd_e  in   5  sources/destination in execute
//   load_e              in   1  instruction in execute is a load
//   pc_src_e            in   1  taken branch or jump in execute
//   rd_m, reg_write_m   in   5/1 memory-stage destination / write enable
//   rd_w, reg_write_w   in   5/1 writeback-stage destination / write enable
//   halt_req            in   1  level debug halt request
//   step_req            in   1  single-step pulse, used only while halted
//   forward_a_e/_b_e    out  2  ALU operand select (00 RF, 10 M, 01 W)
//   stall_f, stall_d    out  1  hold the PC and the F/D register
//   flush_d, flush_e    out  1  clear F/D and D/E to a bubble
//   halted              out  1  registered, high while quiescent
// ---------------------------------------------------------------------------
module hazard_controller
  import pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       srst,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic       load_e,
  input  logic       pc_src_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  input  logic       halt_req,
  input  logic       step_req,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       halted
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  hz_state_t        state;
  hz_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;
  logic     load_use;
  logic     lw_stall;

  // Two copies of the same single-operand forwarding selector, one per ALU
  // source.
  forward_unit u_fwd_a (
    .rs_e        (rs1_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd_sel     (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs_e        (rs2_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd_sel     (fwd_b)
  );

  // The load-use stall only matters while instructions are actually
  // flowing. In DRAIN and HALTED the front end is already frozen and decode
  // is being flushed, so a load-use stall there would only fight the drain.
  assign load_use = is_load_use(load_e, rd_e, rs1_d, rs2_d);
  assign lw_stall = load_use && ((state == HZ_RUN) || (state == HZ_STEP));

  // State register, drain counter and the halted flag. Reset is synchronous
  // and aborts any drain or step in flight. The halted flag is registered
  // from the next state so it rises on the edge that enters HALTED and falls
  // on the edge that leaves it.
  always_ff @(posedge clk) begin
    if (srst) begin
      state  <= HZ_RUN;
      cnt    <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      halted <= (state_next == HZ_HALTED);
    end
  end

  // Next-state and counter logic. The counter is loaded with DRAIN_CYCLES-1
  // on every entry into DRAIN and counts down to zero, so DRAIN lasts exactly
  // DRAIN_CYCLES cycles. A branch in DRAIN does not pause the count; halt_req
  // dropping during DRAIN does not cut it short either, the sequencer still
  // parks in HALTED and only then returns to RUN. A step that hits a
  // load-use waits in STEP until the bubble has been inserted, so the stepped
  // instruction really reaches decode before the drain starts.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      HZ_RUN: begin
        if (halt_req) begin
          state_next = HZ_DRAIN;
          cnt_next   = DRAIN_LOAD;
        end
      end
      HZ_DRAIN: begin
        if (cnt == '0) begin
          state_next = HZ_HALTED;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      HZ_HALTED: begin
        if (!halt_req) begin
          state_next = HZ_RUN;
        end else if (step_req) begin
          state_next = HZ_STEP;
        end
      end
      HZ_STEP: begin
        if (!lw_stall) begin
          state_next = HZ_DRAIN;
          cnt_next   = DRAIN_LOAD;
        end
      end
      default: begin
        state_next = HZ_RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode. Reset forces both pipeline registers to bubbles and
  // removes all stalls and forwarding. A taken branch flushes F/D and D/E in
  // every state and always beats the load-use stall, because the stalled
  // instruction is on the wrong path anyway. While draining or halted the PC
  // is held and decode is fed bubbles; a branch during DRAIN releases the PC
  // for that one cycle so the target is captured before the core parks.
  always_comb begin
    forward_a_e = fwd_a;
    forward_b_e = fwd_b;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    if (srst) begin
      forward_a_e = FWD_RF;
      forward_b_e = FWD_RF;
      flush_d     = 1'b1;
      flush_e     = 1'b1;
    end else begin
      case (state)
        HZ_DRAIN: begin
          stall_f = !pc_src_e;
          flush_d = 1'b1;
          flush_e = pc_src_e;
        end
        HZ_HALTED: begin
          stall_f = 1'b1;
          flush_d = 1'b1;
          flush_e = pc_src_e;
        end
        default: begin
          if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
      endcase
    end
  end

endmodule
